// File: rtl/ifft_seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ifft_seq_pkg: shared state encoding and constants for the IFFT
// frame sequencer.                                     Rev 1.0
// ------------------------------------------------------------------
package ifft_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  localparam int ADDR_STEP         = 4;
  localparam int FRAME_LEN_DEFAULT = 1024;
  localparam int SIDX_W            = $clog2(FRAME_LEN_DEFAULT);

  function automatic int sidx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_fifo2.sv
`default_nettype none
// ------------------------------------------------------------------
// axis_skid_fifo2: 2-entry output skid FIFO (payload + tlast) with
// occupancy count.                                     Rev 1.0
// ------------------------------------------------------------------
module axis_skid_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign w_do_pop  = pop && (r_count != 2'd0);
  assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifft_frame_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// ifft_frame_sequencer: one IFFT config beat, then N frames streamed
// from BRAM to the IFFT. Optional macro PINGPONG_EN.   Rev 1.0
// ------------------------------------------------------------------
module ifft_frame_sequencer #(
  parameter int          FRAME_LEN = 1024,
  parameter int          CFG_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NFRM_W    = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ctrl_start,
  input  logic [NFRM_W-1:0] num_frames,
  input  logic [CFG_W-1:0]  cfg_word,
  output logic [CFG_W-1:0]  ifft_s_axis_config_tdata,
  output logic              ifft_s_axis_config_tvalid,
  input  logic              ifft_s_axis_config_tready,
  output logic [31:0]       ifft_s_axis_data_tdata,
  output logic              ifft_s_axis_data_tvalid,
  output logic              ifft_s_axis_data_tlast,
  input  logic              ifft_s_axis_data_tready,
  output logic [31:0]       bram_addr,
  output logic              bram_en,
  input  logic [31:0]       bram_rdata,
  output logic              busy,
  output logic              done,
`ifdef PINGPONG_EN
  output logic              bank_sel,
`endif
  output logic [NFRM_W-1:0] frame_idx
);

  import ifft_seq_pkg::*;

  localparam int                   SIDX_BITS = sidx_width(FRAME_LEN);
  localparam logic [SIDX_BITS-1:0] SIDX_LAST = SIDX_BITS'(FRAME_LEN - 1);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic                 r_start_q;
  logic [CFG_W-1:0]     r_cfg;
  logic [NFRM_W-1:0]    r_nf_m1;
  logic [SIDX_BITS-1:0] r_sidx;
  logic [NFRM_W-1:0]    r_rd_frame;
  logic [NFRM_W-1:0]    r_frame_idx;
  logic                 r_inflight;
  logic                 r_inflight_last;

  logic        w_start_rise;
  logic        w_pop;
  logic        w_issue;
  logic        w_last_sidx;
  logic        w_last_read;
  logic        w_drain_done;
  logic [2:0]  w_occ_after;
  logic [1:0]  w_fifo_count;
  logic [32:0] w_fifo_head;
  logic [31:0] w_bank_off;

  assign w_start_rise = ctrl_start & ~r_start_q;
  assign w_pop        = ifft_s_axis_data_tvalid & ifft_s_axis_data_tready;

  // Count the beat leaving this cycle so a steady tready=1 stream sustains one read per cycle.
  assign w_occ_after  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == ST_STREAM) && (w_occ_after < 3'd2);
  assign w_last_sidx  = (r_sidx == SIDX_LAST);
  assign w_last_read  = w_issue && w_last_sidx && (r_rd_frame == r_nf_m1);
  assign w_drain_done = !r_inflight &&
                        ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));

`ifdef PINGPONG_EN
  assign w_bank_off = r_rd_frame[0] ? 32'(FRAME_LEN) : 32'd0;
  assign bank_sel   = r_frame_idx[0];
`else
  assign w_bank_off = 32'd0;
`endif

  assign bram_en   = w_issue;
  assign bram_addr = BASE_ADDR + 32'(ADDR_STEP) * (32'(r_sidx) + w_bank_off);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state              = r_state;
    ifft_s_axis_config_tvalid = 1'b0;
    busy                      = 1'b0;
    done                      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) w_next_state = ST_CONFIG;
      end
      ST_CONFIG: begin
        busy                      = 1'b1;
        ifft_s_axis_config_tvalid = 1'b1;
        if (ifft_s_axis_config_tready) w_next_state = ST_STREAM;
      end
      ST_STREAM: begin
        busy = 1'b1;
        if (w_last_read) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_drain_done) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_start_q       <= 1'b0;
      r_cfg           <= '0;
      r_nf_m1         <= '0;
      r_sidx          <= '0;
      r_rd_frame      <= '0;
      r_frame_idx     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_start_q       <= ctrl_start;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && w_last_sidx;
      if ((r_state == ST_IDLE) && w_start_rise) begin
        r_cfg       <= cfg_word;
        r_nf_m1     <= (num_frames == '0) ? '0 : num_frames - NFRM_W'(1);
        r_sidx      <= '0;
        r_rd_frame  <= '0;
        r_frame_idx <= '0;
      end
      if (w_issue) begin
        if (w_last_sidx) begin
          r_sidx     <= '0;
          r_rd_frame <= r_rd_frame + NFRM_W'(1);
        end else begin
          r_sidx <= r_sidx + SIDX_BITS'(1);
        end
      end
      // Output-side frame index follows accepted tlast beats, held at the final frame.
      if (w_pop && w_fifo_head[32] && (r_frame_idx != r_nf_m1))
        r_frame_idx <= r_frame_idx + NFRM_W'(1);
    end
  end

  axis_skid_fifo2 #(
    .WIDTH (33)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (r_inflight),
    .push_data ({r_inflight_last, bram_rdata}),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .count     (w_fifo_count)
  );

  assign ifft_s_axis_config_tdata = r_cfg;
  assign ifft_s_axis_data_tvalid  = (w_fifo_count != 2'd0);
  assign ifft_s_axis_data_tdata   = w_fifo_head[31:0];
  assign ifft_s_axis_data_tlast   = ifft_s_axis_data_tvalid & w_fifo_head[32];
  assign frame_idx                = r_frame_idx;

endmodule
`default_nettype wire

// File: tb/tb_ifft_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_ifft_frame_sequencer: scoreboard bench with randomized backpressure
// and a frame-level reference model.                   Rev 1.0
// ------------------------------------------------------------------
module tb_ifft_frame_sequencer;

  localparam int          FL     = 8;
  localparam int          CFG_W  = 16;
  localparam int          NFRM_W = 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              resetn;
  logic              ctrl_start;
  logic [NFRM_W-1:0] num_frames;
  logic [CFG_W-1:0]  cfg_word;
  logic [CFG_W-1:0]  cfg_tdata;
  logic              cfg_tvalid;
  logic              cfg_tready;
  logic [31:0]       tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic [31:0]       bram_addr;
  logic              bram_en;
  logic [31:0]       bram_rdata = 32'h0;
  logic              busy;
  logic              done;
  logic [NFRM_W-1:0] frame_idx;
`ifdef PINGPONG_EN
  logic              bank_sel;
`endif

  ifft_frame_sequencer #(
    .FRAME_LEN (FL),
    .CFG_W     (CFG_W),
    .BASE_ADDR (BASE),
    .NFRM_W    (NFRM_W)
  ) dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .ctrl_start                (ctrl_start),
    .num_frames                (num_frames),
    .cfg_word                  (cfg_word),
    .ifft_s_axis_config_tdata  (cfg_tdata),
    .ifft_s_axis_config_tvalid (cfg_tvalid),
    .ifft_s_axis_config_tready (cfg_tready),
    .ifft_s_axis_data_tdata    (tdata),
    .ifft_s_axis_data_tvalid   (tvalid),
    .ifft_s_axis_data_tlast    (tlast),
    .ifft_s_axis_data_tready   (tready),
    .bram_addr                 (bram_addr),
    .bram_en                   (bram_en),
    .bram_rdata                (bram_rdata),
    .busy                      (busy),
    .done                      (done),
`ifdef PINGPONG_EN
    .bank_sel                  (bank_sel),
`endif
    .frame_idx                 (frame_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
  endfunction

  // BRAM with one cycle of read latency
  always @(posedge clk) if (bram_en) bram_rdata <= mem_word(bram_addr);

  typedef struct packed {
    logic [31:0]       data;
    logic              last;
    logic [NFRM_W-1:0] frame;
  } beat_t;

  beat_t             beat_q[$];
  logic [CFG_W-1:0]  cfg_q[$];
  logic [31:0]       addr_q[$];

  int n_vec = 0, n_fail = 0;
  int cyc = 0;
  int done_seen = 0, runs_pending = 0;
  int issued = 0, accepted = 0;
  int cfg_acc_cyc = 0, last_acc_cyc = 0, run_beats = 0, cfg_stalls = 0;
  bit want_first = 0, full_rate = 0, prev_stall = 0, prev_done = 0, prev_cfg_acc = 0;
  logic [31:0] prev_tdata = 32'h0;
  logic        prev_tlast = 1'b0;
  beat_t       b;
  int cfg_low = 0, stall = 0, pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event not expected by model (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake driver: config/data tready, updated just after each edge
  initial begin
    cfg_tready = 1'b1;
    tready     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cfg_low > 0) begin cfg_tready = 1'b0; cfg_low--; end
      else cfg_tready = 1'b1;
      if (stall > 0) begin tready = 1'b0; stall--; end
      else tready = ($urandom_range(99) < pct);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall   = 0;
      prev_done    = 0;
      prev_cfg_acc = 0;
    end else begin
      if (prev_cfg_acc) check("cfg_tvalid_drop", 64'(cfg_tvalid), 64'(0));
      if (prev_done)    check("busy_after_done", 64'(busy), 64'(0));
      if (prev_stall) begin
        check("hold_tvalid", 64'(tvalid), 64'(1));
        check("hold_tdata",  64'(tdata),  64'(prev_tdata));
        check("hold_tlast",  64'(tlast),  64'(prev_tlast));
      end
      if (want_first && tvalid) begin
        check("first_valid_latency", 64'(cyc - cfg_acc_cyc), 64'(2));
        want_first = 0;
      end
      if (cfg_tvalid) begin
        if (!cfg_tready) cfg_stalls++;
        if (cfg_q.size() == 0) fail_now("unexpected_config");
        else begin
          check("cfg_tdata", 64'(cfg_tdata), 64'(cfg_q[0]));
          if (cfg_tready) begin
            void'(cfg_q.pop_front());
            cfg_acc_cyc = cyc + 1;
            want_first  = 1;
            run_beats   = 0;
          end
        end
      end
      if (bram_en) issued++;
      if (tvalid && tready) accepted++;
      if (bram_en) begin
        check("read_during_config", 64'(cfg_tvalid), 64'(0));
        check("outstanding_le_2", 64'((issued - accepted) <= 2), 64'(1));
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else check("bram_addr", 64'(bram_addr), 64'(addr_q.pop_front()));
      end
      if (done) begin
        done_seen++;
        if (runs_pending == 0) fail_now("spurious_done");
        else begin
          runs_pending--;
          check("done_after_last_beat", 64'(cyc - last_acc_cyc), 64'(1));
          check("done_queue_empty", 64'(beat_q.size()), 64'(0));
          check("busy_at_done", 64'(busy), 64'(1));
        end
      end
      if (tvalid && tready) begin
        if (beat_q.size() == 0) fail_now("unexpected_beat");
        else begin
          b = beat_q.pop_front();
          check("tdata", 64'(tdata), 64'(b.data));
          check("tlast", 64'(tlast), 64'(b.last));
          check("frame_idx", 64'(frame_idx), 64'(b.frame));
`ifdef PINGPONG_EN
          check("bank_sel", 64'(bank_sel), 64'(b.frame[0]));
`endif
          if (full_rate && run_beats > 0) check("full_rate_gap", 64'(cyc - last_acc_cyc), 64'(1));
        end
        run_beats++;
        last_acc_cyc = cyc;
      end
      prev_stall   = tvalid && !tready;
      prev_tdata   = tdata;
      prev_tlast   = tlast;
      prev_done    = done;
      prev_cfg_acc = cfg_tvalid && cfg_tready;
    end
  end

  // Reference model: a run is a config word then nf frames of FL samples each
  task automatic launch(input int nf, input bit hold);
    int nfe;
    logic [CFG_W-1:0] c;
    nfe = (nf == 0) ? 1 : nf;
    c   = CFG_W'($urandom);
    cfg_q.push_back(c);
    for (int f = 0; f < nfe; f++) begin
      for (int s = 0; s < FL; s++) begin
        int bank;
        logic [31:0] a;
`ifdef PINGPONG_EN
        bank = f % 2;
`else
        bank = 0;
`endif
        a = BASE + 32'(4 * (bank * FL + s));
        addr_q.push_back(a);
        beat_q.push_back('{data: mem_word(a), last: (s == FL - 1), frame: NFRM_W'(f)});
      end
    end
    runs_pending++;
    @(posedge clk); #1;
    num_frames = NFRM_W'(nf);
    cfg_word   = c;
    ctrl_start = 1'b1;
    @(posedge clk); #1;
    if (!hold) ctrl_start = 1'b0;
    num_frames = NFRM_W'($urandom);
    cfg_word   = CFG_W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_seen;
    n    = 0;
    while (done_seen == base && n < budget) begin @(posedge clk); n++; end
    if (done_seen == base) begin
      fail_now("done_timeout");
      beat_q.delete(); addr_q.delete(); cfg_q.delete();
      runs_pending = 0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (accepted < target && n < 2000) begin @(posedge clk); n++; end
    if (accepted < target) fail_now("beat_timeout");
  endtask

  task automatic check_idle_outputs();
    check("rst_cfg_tvalid", 64'(cfg_tvalid), 64'(0));
    check("rst_tvalid",     64'(tvalid),     64'(0));
    check("rst_tlast",      64'(tlast),      64'(0));
    check("rst_bram_en",    64'(bram_en),    64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_done",       64'(done),       64'(0));
    check("rst_bram_addr",  64'(bram_addr),  64'(BASE));
    check("rst_frame_idx",  64'(frame_idx),  64'(0));
`ifdef PINGPONG_EN
    check("rst_bank_sel",   64'(bank_sel),   64'(0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    ctrl_start = 1'b0;
    num_frames = '0;
    cfg_word   = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_idle_outputs();

    // Single frame at full rate
    full_rate = 1; pct = 100;
    launch(1, 0);
    wait_done(500);
    full_rate = 0;

    // Config held off for several cycles
    cfg_stalls = 0;
    cfg_low    = 8;
    launch(2, 0);
    wait_done(1000);
    check("cfg_held_cycles_ge_5", 64'(cfg_stalls >= 5), 64'(1));

    // Three frames under 50% backpressure
    pct = 50;
    launch(3, 0);
    wait_done(2000);

    // Long stall mid-frame
    pct = 100;
    accepted = 0; issued = 0;
    launch(2, 0);
    wait_beats(5);
    stall = 10;
    wait_done(1000);

    // num_frames=0 behaves as one frame
    pct = 70;
    launch(0, 0);
    wait_done(1000);

    // ctrl_start held high must not retrigger
    pct = 100;
    launch(1, 1);
    wait_done(500);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("no_retrigger_busy", 64'(busy), 64'(0));
    #1 ctrl_start = 1'b0;

    // Reset during the second frame, then a clean run
    pct = 80;
    accepted = 0; issued = 0;
    launch(3, 0);
    wait_beats(FL + 3);
    @(posedge clk); #1;
    resetn = 1'b0;
    beat_q.delete(); addr_q.delete(); cfg_q.delete();
    runs_pending = 0; want_first = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    issued = 0; accepted = 0;
    @(negedge clk);
    check_idle_outputs();
    launch(2, 0);
    wait_done(1000);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      pct = $urandom_range(30, 100);
      launch($urandom_range(0, 4), 0);
      wait_done(3000);
    end

    repeat (5) @(posedge clk);
    check("leftover_beats",   64'(beat_q.size()), 64'(0));
    check("leftover_reads",   64'(addr_q.size()), 64'(0));
    check("leftover_configs", 64'(cfg_q.size()),  64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifft_frame_sequencer.md
Name: ifft_frame_sequencer

Overview:
Sequences the transmit IFFT path. On start, it delivers one configuration word to the IFFT config AXI-Stream port. It then streams a programmable number of frames of FRAME_LEN 32-bit samples from the data BRAM to the IFFT data AXI-Stream port. The BRAM has a 1-cycle read latency; IFFT backpressure is honoured with no sample loss or duplication, and tlast is asserted on the last sample of every frame. It sits between the PS-side control registers (ctrl_start, frame count, config word), the data BRAM port and the four lock-stepped IFFT cores (_0 handshake shared by all).

Parameters:
FRAME_LEN, 1024, samples per frame (power of two, 8..4096)
CFG_W, 16, width of IFFT config tdata
BASE_ADDR, 32'h0, BRAM byte base address of sample 0
NFRM_W, 8, width of frame-count input

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
ctrl_start  in  1  level; a 0->1 transition while IDLE starts a run
num_frames  in  NFRM_W  frames per run, sampled at start; 0 treated as 1
cfg_word  in  CFG_W  IFFT config word, sampled at start
ifft_s_axis_config_tdata  out  CFG_W  config payload
ifft_s_axis_config_tvalid  out  1  config valid
ifft_s_axis_config_tready  in  1  config ready
ifft_s_axis_data_tdata  out  32  sample to IFFT
ifft_s_axis_data_tvalid  out  1  sample valid
ifft_s_axis_data_tlast  out  1  last sample of frame
ifft_s_axis_data_tready  in  1  IFFT ready
bram_addr  out  32  BRAM byte address (step 4)
bram_en  out  1  BRAM read enable
bram_rdata  in  32  BRAM data, valid 1 cycle after bram_en
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last beat accepted
frame_idx  out  NFRM_W  index of frame currently being emitted

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, all valids/tlast/bram_en/busy/done=0, bram_addr=BASE_ADDR, frame_idx=0, skid buffer emptied. Reset mid-run aborts immediately; in-flight BRAM data is discarded.
- Clock and reset: one clock (clk); reset resetn is synchronous, active-low.
- States: IDLE -> CONFIG -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: on a registered rising edge of ctrl_start, latch num_frames and cfg_word, set busy, go to CONFIG. A level held high does not retrigger.
- CONFIG: config tvalid=1 with the latched word, held stable until tready. Beat accepted -> tvalid=0 next cycle, go to STREAM.
- STREAM, read issue: read issued (bram_en=1, bram_addr=BASE_ADDR+4*sidx) only when occupancy + reads in flight < 2. Occupancy is that of the 2-entry output skid FIFO.
- STREAM, data path: bram_rdata is pushed into the FIFO on the cycle after issue. data tvalid = FIFO non-empty; tdata = FIFO head.
- STREAM, address: sidx increments per issue and wraps to 0 after FRAME_LEN-1; frame_idx then increments. All FRAME_LEN*nf reads issued -> DRAIN.
- tlast: travels with the word through the FIFO. It is 1 exactly for the word with sidx=FRAME_LEN-1.
- Throughput: with tready held at 1, one beat per cycle after 1-cycle read latency. First data tvalid is 2 cycles after config acceptance.
- Backpressure: while tvalid=1 and tready=0, tdata/tlast stay stable; no BRAM read overwrites held data.
- DRAIN: wait until the FIFO is empty and the last beat is accepted -> DONE.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- ctrl_start deasserting mid-run is ignored; a new start needs ctrl_start low for at least 1 cycle after done.
- Simultaneous FIFO push and pop when full/empty is legal; occupancy unchanged.

Optional Feature:
PINGPONG_EN.
- Defined: frame k reads the BRAM half at offset (k mod 2)*4*FRAME_LEN, so software refills one bank while the other streams. An extra output bank_sel (1 bit) reports the bank of the frame being emitted; reset 0.
- Undefined: every frame re-reads offset 0, and port bank_sel is absent.

Decomposition:
- Shared package ifft_seq_pkg: state enum (IDLE/CONFIG/STREAM/DRAIN/DONE), ADDR_STEP=4, localparam SIDX_W=$clog2(FRAME_LEN).
- Sub-module axis_skid_fifo2: 2-entry, 33-bit (data+tlast) FIFO with count output. Top-level holds FSM and address/frame counters.

Test Plan:
- FRAME_LEN=8, num_frames=1, config tready=1, data tready=1 -> config beat, then 8 beats of BRAM words 0..7; tlast on beat 8 only; done pulse 1 cycle after beat 8.
- Config tready low 5 cycles -> config tvalid held, tdata=cfg_word stable; no bram_en until accepted.
- num_frames=3, tready pseudo-random 50% -> 24 beats in order; tlast on beats 8,16,24; frame_idx 0,1,2; no drop or duplicate.
- tready=0 for 10 cycles mid-frame -> at most 2 reads outstanding; tdata stable; resume yields the next word.
- resetn=0 during frame 2 -> next cycle all outputs at reset values; new start runs clean from sidx 0.
- PINGPONG_EN, num_frames=2 -> addresses 0x0..0x1C, then 0x20..0x3C; bank_sel 0 then 1.
